// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready handshake, bubble-safe control zeroing and a saturating stall counter.
// Define ID_EX_SKID_EN to add a one-entry skid register (capacity 2, registered In_Ready).
`timescale 1ns/1ps

module id_ex_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [15:0]       Stall_Cnt
);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              r_main_vld;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [15:0]       r_stall_cnt;

    logic              w_main_vld_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_stall;

    assign w_out_fire = r_main_vld && Out_Ready;
    assign w_stall    = r_main_vld && !Out_Ready;

`ifdef ID_EX_SKID_EN
    logic              r_skid_vld;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_rdy;

    logic              w_skid_vld_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;

    // In_Ready is a register mirroring "skid empty", so no combinational path from Out_Ready
    assign In_Ready  = r_in_rdy;
    assign w_in_fire = In_Valid && r_in_rdy && !FLUSH;

    always_comb begin
        w_main_vld_nxt  = r_main_vld;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_vld_nxt  = r_skid_vld;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;
        if (FLUSH) begin
            w_main_vld_nxt  = 1'b0;
            w_main_ctrl_nxt = '0;
            w_skid_vld_nxt  = 1'b0;
            w_skid_ctrl_nxt = '0;
        end else if (!r_main_vld || w_out_fire) begin
            if (r_skid_vld) begin
                w_main_vld_nxt  = 1'b1;
                w_main_ctrl_nxt = r_skid_ctrl;
                w_main_data_nxt = r_skid_data;
                w_skid_vld_nxt  = 1'b0;
                w_skid_ctrl_nxt = '0;
            end else if (w_in_fire) begin
                w_main_vld_nxt  = 1'b1;
                w_main_ctrl_nxt = In_Ctrl;
                w_main_data_nxt = In_Data;
            end else begin
                w_main_vld_nxt  = 1'b0;
                w_main_ctrl_nxt = '0;
            end
        end else if (w_in_fire) begin
            w_skid_vld_nxt  = 1'b1;
            w_skid_ctrl_nxt = In_Ctrl;
            w_skid_data_nxt = In_Data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_in_rdy    <= 1'b1;
        end else begin
            r_skid_vld  <= w_skid_vld_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_in_rdy    <= !w_skid_vld_nxt;
        end
    end
`else
    assign In_Ready  = Out_Ready || !r_main_vld;
    assign w_in_fire = In_Valid && In_Ready && !FLUSH;

    always_comb begin
        w_main_vld_nxt  = r_main_vld;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        if (FLUSH) begin
            w_main_vld_nxt  = 1'b0;
            w_main_ctrl_nxt = '0;
        end else if (!r_main_vld || w_out_fire) begin
            if (w_in_fire) begin
                w_main_vld_nxt  = 1'b1;
                w_main_ctrl_nxt = In_Ctrl;
                w_main_data_nxt = In_Data;
            end else begin
                w_main_vld_nxt  = 1'b0;
                w_main_ctrl_nxt = '0;
            end
        end
    end
`endif

    // Control is zeroed whenever the entry leaves or is killed; data only moves on a transfer
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else begin
            r_main_vld  <= w_main_vld_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= sat_inc16(r_stall_cnt);
        end
    end

    assign Out_Valid = r_main_vld;
    assign Out_Ctrl  = r_main_ctrl;
    assign Out_Data  = r_main_data;
    assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: accepted inputs are queued, a monitor pops and compares on each output transfer.
`timescale 1ns/1ps

module tb_id_ex_stage_reg;
    localparam int CW = 16;
    localparam int DW = 128;
`ifdef ID_EX_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          FLUSH;
    logic          In_Valid;
    logic          In_Ready;
    logic [CW-1:0] In_Ctrl;
    logic [DW-1:0] In_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [CW-1:0] Out_Ctrl;
    logic [DW-1:0] Out_Data;
    logic [15:0]   Stall_Cnt;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   nacc;
    logic acc;

    always #5 CLOCK = ~CLOCK;

    id_ex_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .FLUSH(FLUSH),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data),
        .Stall_Cnt(Stall_Cnt)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop before push so an entry is never compared in the cycle it is accepted
    always @(negedge CLOCK) begin
        if (!RESET_N || FLUSH) begin
            sb.delete();
        end else begin
            if (!Out_Valid) chk("bubble_ctrl", Out_Ctrl, '0);
            if (Out_Valid && Out_Ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got ctrl %0h expected none", Out_Ctrl);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_ctrl", Out_Ctrl, mon_e.c);
                    chk("sb_data", Out_Data, mon_e.d);
                end
            end
            if (In_Valid && In_Ready) begin
                mon_e.c = In_Ctrl;
                mon_e.d = In_Data;
                sb.push_back(mon_e);
            end
        end
    end

    task automatic step();
        #2;
        acc = In_Valid && In_Ready && !FLUSH;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; FLUSH = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
        In_Ctrl = '0; In_Data = '0;
        repeat (2) step();
        chk("rst_vld", Out_Valid, 0);
        chk("rst_ctrl", Out_Ctrl, 0);
        chk("rst_data", Out_Data, 0);
        chk("rst_stall", Stall_Cnt, 0);
        chk("rst_in_ready", In_Ready, 1);

        // single entry, one-cycle latency
        RESET_N = 1'b1;
        In_Valid = 1'b1; In_Ctrl = 16'h00A5; In_Data = 128'h1234; Out_Ready = 1'b1;
        step();
        In_Valid = 1'b0;
        chk("lat_vld", Out_Valid, 1);
        chk("lat_ctrl", Out_Ctrl, 16'h00A5);
        chk("lat_data", Out_Data, 128'h1234);
        step();
        chk("lat_drained", Out_Valid, 0);

        // back-to-back stream, no bubbles
        for (int i = 1; i <= 8; i++) begin
            In_Valid = 1'b1; In_Ctrl = CW'(i); In_Data = 128'hABC0_0000 + DW'(i);
            step();
            chk("stream_vld", Out_Valid, 1);
            chk("stream_ctrl", Out_Ctrl, DW'(i));
        end
        In_Valid = 1'b0;
        step();
        chk("stream_stall", Stall_Cnt, 0);

        // back-pressure: prefill one entry, then 5 stalled cycles
        nacc = 0;
        In_Valid = 1'b1; In_Ctrl = 16'h0020; In_Data = 128'h2000; Out_Ready = 1'b1;
        step();
        if (acc) begin nacc++; In_Ctrl++; In_Data++; end
        Out_Ready = 1'b0;
        repeat (5) begin
            step();
            if (acc) begin nacc++; In_Ctrl++; In_Data++; end
        end
        chk("stall_accepted", nacc, EXP_ACC);
        chk("stall_in_ready", In_Ready, 0);
        chk("stall_cnt5", Stall_Cnt, 5);
        In_Valid = 1'b0; Out_Ready = 1'b1;
        repeat (3) step();
        chk("stall_drained", Out_Valid, 0);

        // flush with stage full and an input offered
        Out_Ready = 1'b0; In_Valid = 1'b1; In_Ctrl = 16'h0030; In_Data = 128'h3030;
        step();
        In_Ctrl = 16'h0031; In_Data = 128'h3131;
        step();
        FLUSH = 1'b1; In_Ctrl = 16'h003E; In_Data = 128'h3E3E;
        step();
        FLUSH = 1'b0; In_Valid = 1'b0;
        chk("flush_vld", Out_Valid, 0);
        chk("flush_ctrl", Out_Ctrl, 0);
        chk("flush_in_ready", In_Ready, 1);
        chk("flush_data_held", Out_Data, 128'h3030);
        chk("flush_stall_kept", Stall_Cnt, 7);
        Out_Ready = 1'b1;
        repeat (3) step();
        chk("flush_nothing_out", Out_Valid, 0);

        // long stall: counter saturates, then async reset mid-stall
        Out_Ready = 1'b0; In_Valid = 1'b1; In_Ctrl = 16'h0077; In_Data = 128'h7777;
        step();
        In_Valid = 1'b0;
        repeat (70000) step();
        chk("sat_stall", Stall_Cnt, 16'hFFFF);
        chk("sat_vld", Out_Valid, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_vld", Out_Valid, 0);
        chk("arst_ctrl", Out_Ctrl, 0);
        chk("arst_data", Out_Data, 0);
        chk("arst_stall", Stall_Cnt, 0);
        chk("arst_in_ready", In_Ready, 1);
        step();
        RESET_N = 1'b1;
        In_Valid = 1'b1; In_Ctrl = 16'h0088; In_Data = 128'h8888; Out_Ready = 1'b1;
        step();
        In_Valid = 1'b0;
        chk("post_rst_vld", Out_Valid, 1);
        chk("post_rst_ctrl", Out_Ctrl, 16'h0088);
        chk("post_rst_data", Out_Data, 128'h8888);
        repeat (2) step();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the control bundle (write enables, branch flags, ALU controls).
REQ-002 SHALL have parameter DATA_W, default 128, width of the data bundle (register operands, addresses, immediate, PC).
REQ-003 SHALL have CLOCK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have FLUSH  input  1  synchronous kill of all held and incoming entries.
REQ-006 SHALL have In_Valid  input  1  ID stage offers an entry.
REQ-007 SHALL have In_Ready  output  1  stage accepts the entry this cycle.
REQ-008 SHALL have In_Ctrl  input  CTRL_W  control bundle from decode.
REQ-009 SHALL have In_Data  input  DATA_W  data bundle from decode.
REQ-010 SHALL have Out_Valid  output  1  EX stage entry valid.
REQ-011 SHALL have Out_Ready  input  1  EX stage consumes the entry this cycle.
REQ-012 SHALL have Out_Ctrl  output  CTRL_W  registered control bundle.
REQ-013 SHALL have Out_Data  output  DATA_W  registered data bundle.
REQ-014 SHALL have Stall_Cnt  output  16  count of back-pressured cycles.

Function
REQ-015 Input transfer SHALL occur when In_Valid && In_Ready; output transfer when Out_Valid && Out_Ready.
REQ-016 Latency SHALL be one cycle: an entry accepted at edge N is on Out_* after edge N when the stage was empty or drains at N.
REQ-017 Entries SHALL leave in acceptance order; none duplicated or dropped except by FLUSH.
REQ-018 Whenever Out_Valid is 0, Out_Ctrl SHALL be all zeros (bubble: no downstream writes or branches).
REQ-019 FLUSH high at an edge SHALL clear every valid bit and zero every held control bundle; an input offered that cycle SHALL be discarded; FLUSH overrides all other events.
REQ-020 Data registers SHALL load only on an accepted transfer; held data SHALL not change on stall or flush.
REQ-021 Stall_Cnt SHALL increment each cycle Out_Valid && !Out_Ready, saturate at 16'hFFFF, and not be cleared by FLUSH.
REQ-022 Simultaneous input and output transfer on a full main register SHALL replace it with the new entry in the same edge, no bubble.

Reset
REQ-023 RESET_N low SHALL immediately force Out_Valid=0, Out_Ctrl=0, Out_Data=0, skid storage empty and zeroed, Stall_Cnt=0.
REQ-024 In_Ready SHALL be 1 during and after reset.
REQ-025 Reset asserted mid-stall SHALL discard all held entries; first cycle after release behaves as empty stage.

Configuration
REQ-026 Macro ID_EX_SKID_EN defined SHALL add a one-entry skid register: In_Ready is registered and equals "skid empty"; an input accepted while main is full and Out_Ready=0 goes to skid; skid moves to main on the next output transfer; capacity 2.
REQ-027 Macro ID_EX_SKID_EN undefined SHALL build a single register: In_Ready = Out_Ready || !Out_Valid (combinational); capacity 1.

Verification
REQ-028 Reset release, In_Valid=1, In_Ctrl=16'h00A5, In_Data=128'h1234, Out_Ready=1 -> Out_Valid=1, Out_Ctrl=16'h00A5, Out_Data=128'h1234 one cycle later.
REQ-029 Stream entries 1..8 every cycle, Out_Ready=1 -> outputs 1..8 on consecutive cycles, no bubbles, Stall_Cnt=0.
REQ-030 Out_Ready=0 for 5 cycles with input streaming -> (SKID_EN) In_Ready falls after 2 accepted, (no SKID_EN) after 1; Stall_Cnt=5; release gives order preserved.
REQ-031 FLUSH pulse with stage full and In_Valid=1 -> next cycle Out_Valid=0, Out_Ctrl=0, skid empty, flushed input never appears.
REQ-032 Hold Out_Valid=1, Out_Ready=0 for 70000 cycles -> Stall_Cnt=16'hFFFF, no wrap; RESET_N pulse mid-stall -> all outputs zero asynchronously.
